// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared FSM state type and default sizing for the FIFO write arbiter
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_BURST_MAX  = 4;

endpackage

// File: rtl/fifo_rr_pick.sv
// rtl/fifo_rr_pick.sv - rotating-priority pick starting one past the last winner
module fifo_rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IW-1:0]      last_winner_i,
    output logic [IW-1:0]      winner_o,
    output logic               valid_o
);

    logic [IW-1:0] idx;

    // Walk from the farthest offset down so the nearest pending requester wins;
    // offset NUM_REQ is the last winner itself, so it only wins when alone.
    always_comb begin
        winner_o = '0;
        valid_o  = 1'b0;
        idx      = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = IW'((int'(last_winner_i) + k) % NUM_REQ);
            if (req_i[idx]) begin
                winner_o = idx;
                valid_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter feeding one FIFO write port
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int BURST_MAX  = DEF_BURST_MAX
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            ack,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_data,
    input  logic                          fifo_full,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy
);

    localparam int IW = $clog2(NUM_REQ);

    arb_state_e    state_q, state_d;
    logic [IW-1:0] grant_q, grant_d;
    logic [IW-1:0] last_q, last_d;
    logic [3:0]    beat_q, beat_d;

    logic [IW-1:0] pick_base, pick_id;
    logic          pick_valid;
    logic          gnt_req, accept, rel;
    logic [4:0]    beat_inc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= IW'(NUM_REQ - 1);
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            beat_q  <= beat_d;
        end
    end

    // On release the search starts after the outgoing holder, which is the
    // last_winner value being written at that same edge.
    assign pick_base = (state_q == GRANT) ? grant_q : last_q;

    fifo_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_pick (
        .req_i         (req),
        .last_winner_i (pick_base),
        .winner_o      (pick_id),
        .valid_o       (pick_valid)
    );

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_d     = last_q;
        beat_d     = beat_q;
        ack        = '0;
        fifo_wr_en = 1'b0;
        fifo_data  = '0;
        rel        = 1'b0;
        gnt_req    = req[grant_q];
        accept     = (state_q == GRANT) && gnt_req && !fifo_full;
        beat_inc   = {1'b0, beat_q} + 5'd1;

        if (accept) begin
            ack[grant_q] = 1'b1;
            fifo_wr_en   = 1'b1;
            fifo_data    = req_data[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
        end

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = GRANT;
                    grant_d = pick_id;
                    beat_d  = '0;
                end
            end
            GRANT: begin
                if (!gnt_req) begin
                    rel = 1'b1;
                end else if (accept) begin
                    if (req_last[grant_q] || (beat_inc == 5'(BURST_MAX))) begin
                        rel = 1'b1;
                    end else begin
                        beat_d = beat_inc[3:0];
                    end
                end

                if (rel) begin
                    last_d = grant_q;
                    beat_d = '0;
                    if (pick_valid) begin
                        grant_d = pick_id;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                    end
                end
            end
        endcase
    end

    assign grant_id = grant_q;
    assign busy     = (state_q == GRANT);

endmodule
